// File: rtl/aes_pkg.sv
// Shared AES types, round constants and key-schedule state encoding.
package aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  localparam int AES_NR = 10;

  localparam logic [7:0] AES_RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } aes_state_e;

  // rcon for the step that produces round key idx+1; idx 10 never steps forward
  function automatic logic [7:0] aes_rcon(input logic [3:0] idx);
    return (idx < 4'd10) ? AES_RCON[idx] : 8'h00;
  endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: byte-wise S-box over a 32-bit word, purely combinational.
module aes_subword
  import aes_pkg::*;
(
  input  aes_word_t word_in,
  output aes_word_t word_out
);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    sbox u_sbox (
      .x (word_in[8*i +: 8]),
      .y (word_out[8*i +: 8])
    );
  end

endmodule

// File: rtl/sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv = gf_inv(x);
    y   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule emitting round keys 0..10 over valid/ready.
// Optional AES_KEY_ZEROIZE_EN clears the key register on the final accept.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] key_in,
  output logic          rk_valid,
  input  logic          rk_ready,
  output logic [KW-1:0] rk_out,
  output logic [3:0]    rk_idx,
  output logic          busy,
  output logic          done
);

  if (NR != AES_NR || KW != 128) begin : g_bad_cfg
    $error("aes_key_expand supports only AES-128 (NR=10, KW=128)");
  end

  aes_state_e state;
  aes_block_t key_q;
  aes_word_t  w0, w1, w2, w3;
  aes_word_t  rot, sub, t;
  aes_word_t  n0, n1, n2, n3;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  aes_subword u_subword (
    .word_in  (rot),
    .word_out (sub)
  );

  assign t  = sub ^ {aes_rcon(rk_idx), 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rk_out = key_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      key_q    <= '0;
      rk_idx   <= 4'd0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            key_q    <= key_in;
            rk_idx   <= 4'd0;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (rk_valid && rk_ready) begin
            if (rk_idx == 4'(AES_NR)) begin
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= ST_IDLE;
`ifdef AES_KEY_ZEROIZE_EN
              key_q    <= '0;
`else
              key_q    <= key_q;
`endif
            end else begin
              key_q  <= {n0, n1, n2, n3};
              rk_idx <= rk_idx + 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: vector table plus handshake scoreboard.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_idx   (rk_idx),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic [127:0]        key;
    logic [10:0][127:0]  rk;
    logic [10:0]         chk;
  } vec_t;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] val;
    bit           chk;
  } exp_t;

  vec_t vecs [0:1];
  exp_t sb_q [$];

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;

  bit           prev_stall = 0;
  logic [127:0] prev_out;
  logic [3:0]   prev_idx;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Handshake monitor: pops the scoreboard on every accepted key, checks stall stability
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {127'd0, rk_valid}, 128'd1);
        check("stall_out", rk_out, prev_out);
        check("stall_idx", {124'd0, rk_idx}, {124'd0, prev_idx});
      end
      if (rk_valid && rk_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_key", {124'd0, rk_idx}, 128'hffff);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("key_idx", {124'd0, rk_idx}, {124'd0, e.idx});
          if (e.chk) check("key_val", rk_out, e.val);
        end
      end
`ifdef AES_KEY_ZEROIZE_EN
      if (!rk_valid) check("zero_when_idle", rk_out, 128'd0);
`endif
      prev_stall = rk_valid && !rk_ready;
      prev_out   = rk_out;
      prev_idx   = rk_idx;
      if (done) done_cnt++;
    end
  end

  task automatic push_expected(input int v);
    for (int i = 0; i <= 10; i++)
      sb_q.push_back('{idx: 4'(i), val: vecs[v].rk[i], chk: vecs[v].chk[i]});
  endtask

  task automatic expand(input int v, input int pct, input bit poke4, input bit post_check);
    int cnt;
    bit poked;
    logic [127:0] final_key;
    push_expected(v);
    start  = 1'b1;
    key_in = vecs[v].key;
    @(posedge clk); #1;
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    cnt    = 1;
    poked  = 0;
    check("key0_start", {122'd0, rk_valid, busy, rk_idx}, {122'd0, 1'b1, 1'b1, 4'd0});
    while (!done && cnt < 300) begin
      rk_ready = ($urandom_range(0, 99) < pct);
      if (poke4 && !poked && rk_idx == 4'd4) begin
        start  = 1'b1;
        key_in = vecs[1 - v].key ^ 128'h5a;
        poked  = 1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cnt++;
    end
    check("done_seen", {127'd0, done}, 128'd1);
    if (pct >= 100) check("done_latency", 128'(cnt), 128'd12);
    if (poke4) check("poke_applied", {127'd0, poked}, 128'd1);
    check("all_keys_out", 128'(sb_q.size()), 128'd0);
    check("post_done_flags", {126'd0, rk_valid, busy}, 128'd0);
`ifdef AES_KEY_ZEROIZE_EN
    final_key = 128'd0;
`else
    final_key = vecs[v].rk[10];
`endif
    if (post_check) begin
      check("post_done_out", rk_out, final_key);
      @(posedge clk); #1;
      check("done_one_cycle", {127'd0, done}, 128'd0);
      check("post_done_hold", rk_out, final_key);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int d0;

    vecs[0].key    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    vecs[0].rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    vecs[0].rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    vecs[0].rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    vecs[0].rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    vecs[0].rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    vecs[0].rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    vecs[0].rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    vecs[0].rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    vecs[0].rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    vecs[0].rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    vecs[0].rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    vecs[0].chk    = 11'h7ff;

    vecs[1].key    = 128'd0;
    vecs[1].rk     = '0;
    vecs[1].rk[1]  = 128'h62636363626363636263636362636363;
    vecs[1].rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    vecs[1].chk    = 11'b100_0000_0011;

    rst_n    = 1'b0;
    start    = 1'b0;
    key_in   = '0;
    rk_ready = 1'b0;
    #23;
    check("reset_out", rk_out, 128'd0);
    check("reset_flags", {121'd0, rk_valid, busy, done, rk_idx}, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_no_start", {127'd0, rk_valid}, 128'd0);

    for (int v = 0; v < 2; v++) expand(v, 100, 0, 1);

    expand(0, 50, 0, 1);

    // start while busy is ignored; start in the done cycle begins a new run
    expand(0, 100, 1, 0);
    expand(1, 100, 0, 1);

    // asynchronous abort at idx 6
    push_expected(0);
    start  = 1'b1;
    key_in = vecs[0].key;
    rk_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt   = 0;
    while (rk_idx != 4'd6 && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("reached_idx6", {124'd0, rk_idx}, 128'd6);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("abort_out", rk_out, 128'd0);
    check("abort_flags", {121'd0, rk_valid, busy, done, rk_idx}, 128'd0);
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", 128'(done_cnt), 128'(d0));
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    expand(0, 100, 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
